// File: rtl/io_debounce.sv
// Per-bit pad conditioner: two-flop synchronizer, debounce, polarity normalization and
// press / release / long-press events. The release event port is named release_pulse.
module io_debounce #(
  parameter int unsigned SW     = 1,
  parameter logic        DS     = 1'b0,
  parameter int unsigned DB_CYC = 16,
  parameter int unsigned CW     = 16,
  parameter int unsigned LP_CYC = 1000,
  parameter int unsigned LW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] io_in,
  output logic [SW-1:0] level,
  output logic [SW-1:0] press,
  output logic [SW-1:0] release_pulse,
  output logic [SW-1:0] long,
  output logic [SW-1:0] held
);

  // Terminal counts, truncated to the counter widths.
  localparam logic [CW-1:0] DbLast = CW'(DB_CYC - 1);
  localparam logic [LW-1:0] LpLast = LW'(LP_CYC - 1);

  if (DB_CYC == 0 || (64'(DB_CYC) >> CW) != 64'd0) begin : g_bad_db_cyc
    $error("io_debounce: DB_CYC=%0d is outside 1..2^CW-1 (CW=%0d)", DB_CYC, CW);
  end

  if (LP_CYC == 0 || (64'(LP_CYC) >> LW) != 64'd0) begin : g_bad_lp_cyc
    $error("io_debounce: LP_CYC=%0d is outside 1..2^LW-1 (LW=%0d)", LP_CYC, LW);
  end

  for (genvar i = 0; i < SW; i++) begin : g_bit
    logic          s1_q, s2_q;
    logic          a;
    logic [CW-1:0] dc_d, dc_q;
    logic          level_d, level_q;
    logic          level_dly_q;
    logic [LW-1:0] lc_d, lc_q;
    logic          press_d, press_q;
    logic          release_d, release_q;
    logic          long_d, long_q;
    logic          held_d, held_q;

    assign a = s2_q ^ DS;

    // Debounce: any sample agreeing with level restarts the count.
    always_comb begin
      dc_d    = '0;
      level_d = level_q;
      if (a != level_q) begin
        if (dc_q == DbLast) begin
          level_d = a;
        end else begin
          dc_d = dc_q + CW'(1);
        end
      end
    end

    // Edge events lag the level change by one cycle.
    always_comb begin
      press_d   = level_q & ~level_dly_q;
      release_d = ~level_q & level_dly_q;
    end

    // Long press: lc freezes once held is set, so long fires once per press.
    always_comb begin
      lc_d   = lc_q;
      long_d = 1'b0;
      held_d = held_q;
      if (!level_q) begin
        lc_d   = '0;
        held_d = 1'b0;
      end else if (!held_q) begin
        if (lc_q == LpLast) begin
          long_d = 1'b1;
          held_d = 1'b1;
        end else begin
          lc_d = lc_q + LW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q        <= DS;
        s2_q        <= DS;
        dc_q        <= '0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        lc_q        <= '0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        held_q      <= 1'b0;
      end else begin
        s1_q        <= io_in[i];
        s2_q        <= s1_q;
        dc_q        <= dc_d;
        level_q     <= level_d;
        level_dly_q <= level_q;
        lc_q        <= lc_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        held_q      <= held_d;
      end
    end

    // Outputs are forced low while rst is asserted, even before the first reset edge.
    assign level[i]         = level_q & ~rst;
    assign press[i]         = press_q & ~rst;
    assign release_pulse[i] = release_q & ~rst;
    assign long[i]          = long_q & ~rst;
    assign held[i]          = held_q & ~rst;
  end

endmodule

// File: tb/tb_io_debounce.sv
// Randomized bench for io_debounce: a 1-bit active-high instance and a 4-bit active-low
// instance run side by side against a window / run-length reference model.
module tb_io_debounce;

  localparam int unsigned DB = 16;
  localparam int unsigned LP = 100;
  localparam int          NB = 5;
  // Bit 0 is instance A (DS=0); bits 4:1 are instance B (DS=1).
  localparam logic [NB-1:0] DSV = 5'b11110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_a = 1'b0;
  logic [3:0] io_b = 4'hF;

  logic       lvl_a, prs_a, rel_a, lng_a, hld_a;
  logic [3:0] lvl_b, prs_b, rel_b, lng_b, hld_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_debounce #(
    .SW(1), .DS(1'b0), .DB_CYC(DB), .CW(16), .LP_CYC(LP), .LW(24)
  ) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .io_in        (io_a),
    .level        (lvl_a),
    .press        (prs_a),
    .release_pulse(rel_a),
    .long         (lng_a),
    .held         (hld_a)
  );

  io_debounce #(
    .SW(4), .DS(1'b1), .DB_CYC(DB), .CW(16), .LP_CYC(LP), .LW(24)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .io_in        (io_b),
    .level        (lvl_b),
    .press        (prs_b),
    .release_pulse(rel_b),
    .long         (lng_b),
    .held         (hld_b)
  );

  // Reference model state.
  logic [NB-1:0] cap1, cap2;        // normalized pad value seen one / two edges ago
  logic [DB-1:0] hist [NB];         // last DB normalized samples fed to the debouncer
  int            nvalid [NB];
  logic [NB-1:0] lvl1, lvl2;        // expected level after the last / previous edge
  int            run [NB];          // consecutive edges the level has been active
  logic [NB-1:0] x_level, x_press, x_release, x_long, x_held;

  task automatic check_eq(input string tag, input logic [NB-1:0] got,
                          input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] norm;
    logic [NB-1:0] nl;
    logic          want;
    norm = {io_b, io_a} ^ DSV;
    nl   = '0;
    if (rst) begin
      cap1 = '0;
      cap2 = '0;
      lvl1 = '0;
      lvl2 = '0;
      for (int b = 0; b < NB; b++) begin
        hist[b]   = '0;
        nvalid[b] = 0;
        run[b]    = 0;
      end
      x_level   = '0;
      x_press   = '0;
      x_release = '0;
      x_long    = '0;
      x_held    = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        x_press[b]   = lvl1[b] & ~lvl2[b];
        x_release[b] = ~lvl1[b] & lvl2[b];
        x_long[b]    = lvl1[b] && (run[b] == LP);
        x_held[b]    = lvl1[b] && (run[b] >= LP);
        hist[b]      = {hist[b][DB-2:0], cap2[b]};
        if (nvalid[b] < DB) nvalid[b]++;
        want  = ~lvl1[b];
        nl[b] = lvl1[b];
        if (nvalid[b] == DB && hist[b] == {DB{want}}) nl[b] = want;
        run[b] = nl[b] ? run[b] + 1 : 0;
      end
      lvl2    = lvl1;
      lvl1    = nl;
      x_level = nl;
      cap2    = cap1;
      cap1    = norm;
    end
  endtask

  task automatic step(input logic a, input logic [3:0] b, input logic r);
    @(negedge clk);
    io_a = a;
    io_b = b;
    rst  = r;
    @(posedge clk);
    #1;
    model_edge();
    check_eq("level",   {lvl_b, lvl_a}, x_level);
    check_eq("press",   {prs_b, prs_a}, x_press);
    check_eq("release", {rel_b, rel_a}, x_release);
    check_eq("long",    {lng_b, lng_a}, x_long);
    check_eq("held",    {hld_b, hld_a}, x_held);
  endtask

  task automatic hold(input logic a, input logic [3:0] b, input logic r, input int n);
    repeat (n) step(a, b, r);
  endtask

  initial begin
    logic [NB-1:0] act;
    logic [NB-1:0] raw;
    int            dur [NB];
    int            mode;
    int            rst_left;
    logic          r;

    // Reset with every pad at its inactive level, then idle.
    hold(1'b0, 4'hF, 1'b1, 3);
    hold(1'b0, 4'hF, 1'b0, 10);
    // Clean press with long press on A and on B bit 2 only.
    hold(1'b1, 4'b1011, 1'b0, 220);
    hold(1'b0, 4'hF, 1'b0, 40);
    // Glitch one cycle short of the debounce window.
    hold(1'b1, 4'b0000, 1'b0, 15);
    hold(1'b0, 4'hF, 1'b0, 30);
    // Bounce every 5 cycles, then settle active.
    for (int k = 0; k < 12; k++) begin
      hold((k % 2) == 0, ((k % 2) == 0) ? 4'h0 : 4'hF, 1'b0, 5);
    end
    hold(1'b1, 4'h0, 1'b0, 40);
    hold(1'b0, 4'hF, 1'b0, 40);
    // Reset mid-debounce with the input held active.
    hold(1'b1, 4'hE, 1'b0, 12);
    hold(1'b1, 4'hE, 1'b1, 1);
    hold(1'b1, 4'hE, 1'b0, 40);
    hold(1'b0, 4'hF, 1'b0, 30);
    // Reset mid-long-press.
    hold(1'b1, 4'h7, 1'b0, 70);
    hold(1'b1, 4'h7, 1'b1, 1);
    hold(1'b1, 4'h7, 1'b0, 140);
    hold(1'b0, 4'hF, 1'b0, 30);

    // Randomized per-bit hold times around the debounce and long-press thresholds.
    act      = '0;
    rst_left = 0;
    for (int b = 0; b < NB; b++) dur[b] = 0;
    for (int c = 0; c < 6000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (dur[b] == 0) begin
          act[b] = ~act[b];
          mode   = $urandom_range(0, 9);
          if (mode < 4)      dur[b] = $urandom_range(1, 8);
          else if (mode < 7) dur[b] = $urandom_range(12, 20);
          else               dur[b] = $urandom_range(95, 180);
        end
        dur[b]--;
      end
      r = 1'b0;
      if (rst_left > 0) begin
        r = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        r        = 1'b1;
        rst_left = $urandom_range(0, 1);
      end
      raw = act ^ DSV;
      step(raw[0], raw[4:1], r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
